// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive blocks.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Reloadable oversample down-counter; bit_end marks the last tick of a serial bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    input  logic t_enable,
    output logic bit_end
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] TOP = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] count_q;

    assign bit_end = run && t_enable && (count_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (restart) begin
            count_q <= TOP;
        end else if (run && t_enable) begin
            count_q <= (count_q == '0) ? TOP : count_q - 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// Double-buffered 8N1 UART transmitter driven by the shared 16x oversample tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 t_enable,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] din,
    output logic                 txd,
    output logic                 tbr,
    output logic                 busy
);

    localparam int unsigned BCW = $clog2(DATA_BITS);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full_q;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 txd_q, txd_d;
    logic                 bit_end;
    logic                 transfer;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // Holding register moves into the shifter from IDLE, or straight from the end of STOP.
    assign transfer = hold_full_q && t_enable &&
                      ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (state_q != IDLE),
        .restart  (transfer),
        .t_enable (t_enable),
        .bit_end  (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (transfer) begin
            hold_full_q <= 1'b0;
        end else if (load && !hold_full_q) begin
            hold_q      <= din;
            hold_full_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        txd_d     = txd_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            IDLE: txd_d = 1'b1;
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    txd_d     = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = parity_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        txd_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
        // A pending byte overrides the IDLE/STOP outcome and opens the next frame.
        if (transfer) begin
            state_d = START;
            txd_d   = 1'b0;
            shift_d = hold_q;
`ifdef UART_TX_PARITY_EN
            parity_d = ^hold_q;
`endif
        end
    end

    assign txd  = txd_q;
    assign tbr  = !hold_full_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a behavioural tick-level line receiver decodes txd frames.
// Build with +define+UART_TX_PARITY_EN to exercise the parity bit.
module tb_uart_transmitter;

    localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       t_enable = 1'b0;
    logic       load = 1'b0;
    logic [7:0] din = 8'h00;
    logic       txd, tbr, busy;

    int tests = 0;
    int fails = 0;
    int te_period = 1;
    int te_phase = 0;
    int ci = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_data[$];
    int         rx_err[$];
    logic       rx_par[$];
    longint     rx_start[$];
    int         off_tick = 0;

    uart_transmitter dut (
        .clk      (clk),
        .rst      (rst),
        .t_enable (t_enable),
        .load     (load),
        .din      (din),
        .txd      (txd),
        .tbr      (tbr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            te_phase = (te_phase + 1) % te_period;
            t_enable = (te_phase == 0);
        end
    end

    // Line receiver: one sample per tick, a frame is NB bits of OS ticks from the falling edge.
    initial begin
        logic   te_s, rst_s, prev_txd, in_frame, mid, par;
        logic   wave[NB*OS];
        int     fidx, errs;
        logic [7:0] data;
        longint clk_no, start_clk;
        prev_txd = 1'b1;
        in_frame = 1'b0;
        clk_no = 0;
        start_clk = 0;
        fidx = 0;
        forever begin
            @(posedge clk);
            te_s = t_enable;
            rst_s = rst;
            #1;
            clk_no++;
            if (rst_s) in_frame = 1'b0;
            else if (txd !== prev_txd && !te_s) off_tick++;
            if (!rst_s && te_s) begin
                if (!in_frame && txd === 1'b0) begin
                    in_frame = 1'b1;
                    fidx = 0;
                    start_clk = clk_no;
                end
                if (in_frame) begin
                    wave[fidx] = txd;
                    fidx++;
                    if (fidx == NB*OS) begin
                        errs = 0;
                        data = 8'h00;
                        for (int k = 0; k < NB; k++) begin
                            mid = wave[k*OS + OS/2];
                            for (int j = 0; j < OS; j++)
                                if (wave[k*OS + j] !== mid) errs++;
                            if (k >= 1 && k <= 8) data[k-1] = mid;
                        end
                        if (wave[OS/2] !== 1'b0) errs++;
                        if (wave[(NB-1)*OS + OS/2] !== 1'b1) errs++;
                        par = 1'b0;
`ifdef UART_TX_PARITY_EN
                        par = wave[9*OS + OS/2];
                        if (par !== ^data) errs++;
`endif
                        rx_data.push_back(data);
                        rx_err.push_back(errs);
                        rx_par.push_back(par);
                        rx_start.push_back(start_clk);
                        in_frame = 1'b0;
                    end
                end
            end
            prev_txd = txd;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] b);
        @(negedge clk);
        load = 1'b1;
        din = b;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_tbr(input string tag);
        int n = 0;
        while (tbr !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(tbr), 32'd1);
    endtask

    task automatic wait_fall(input string tag);
        int n = 0;
        while (txd !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(txd), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy !== 1'b0 || tbr !== 1'b1) && n < 8000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_rx(input string tag, input int count);
        int n = 0;
        while (rx_data.size() < count && n < 12000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(rx_data.size()), 32'(count));
    endtask

    task automatic check_frames();
        for (int i = ci; i < exp_q.size() && i < rx_data.size(); i++) begin
            chk("rx_data", 32'(rx_data[i]), 32'(exp_q[i]));
            chk("rx_bit_errors", 32'(rx_err[i]), 32'd0);
        end
        ci = exp_q.size();
    endtask

    initial begin
        int         base, c;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_tbr", 32'(tbr), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xA5 with a tick every cycle: exact cycle timing of transfer, start, bit 0, stop
        do_load(8'hA5);
        chk("a5_tbr_after_load", 32'(tbr), 32'd0);
        chk("a5_txd_before_xfer", 32'(txd), 32'd1);
        @(negedge clk);
        exp_q.push_back(8'hA5);
        chk("a5_xfer_txd", 32'(txd), 32'd0);
        chk("a5_xfer_tbr", 32'(tbr), 32'd1);
        chk("a5_xfer_busy", 32'(busy), 32'd1);
        repeat (15) @(negedge clk);
        chk("a5_start_last", 32'(txd), 32'd0);
        @(negedge clk);
        chk("a5_bit0", 32'(txd), 32'd1);
        repeat (NB*OS - 1 - 16) @(negedge clk);
        chk("a5_stop_txd", 32'(txd), 32'd1);
        chk("a5_busy_stop_last", 32'(busy), 32'd1);
        @(negedge clk);
        chk("a5_busy_end", 32'(busy), 32'd0);
        wait_rx("a5_rx", 1);
        check_frames();

        // Back-to-back 0x55, 0x0F; a third load while the buffer is full is dropped
        wait_idle("b2b_idle");
        base = rx_data.size();
        do_load(8'h55);
        exp_q.push_back(8'h55);
        wait_tbr("b2b_tbr");
        do_load(8'h0F);
        exp_q.push_back(8'h0F);
        repeat (20) @(negedge clk);
        chk("b2b_tbr_full", 32'(tbr), 32'd0);
        do_load(8'hEE);
        wait_rx("b2b_rx", base + 2);
        check_frames();
        chk("b2b_gap", 32'(rx_start[base+1] - rx_start[base]), 32'(NB*OS));
        repeat (NB*OS + 40) @(negedge clk);
        chk("b2b_third_dropped", 32'(rx_data.size()), 32'(base + 2));

        // Tick every 4th clock: frame spans 4x the clocks
        wait_idle("te4_idle");
        te_period = 4;
        b = 8'($urandom);
        do_load(b);
        exp_q.push_back(b);
        wait_fall("te4_fall");
        c = 0;
        while (busy === 1'b1 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        chk("te4_frame_clocks", 32'(c), 32'(NB*OS*4));
        wait_rx("te4_rx", exp_q.size());
        check_frames();
        chk("te4_off_tick", 32'(off_tick), 32'd0);

        // Random bytes loaded as soon as the buffer frees, random tick rate
        wait_idle("rand_idle");
        te_period = $urandom_range(1, 3);
        base = rx_data.size();
        for (int i = 0; i < 6; i++) begin
            wait_tbr("rand_tbr");
            b = 8'($urandom);
            do_load(b);
            exp_q.push_back(b);
        end
        wait_rx("rand_rx", base + 6);
        check_frames();
        for (int i = 1; i < 6; i++)
            chk("rand_gap", 32'(rx_start[base+i] - rx_start[base+i-1]), 32'(NB*OS*te_period));

        // Reset during data bit 3 of 0xFF with 0x81 held: both discarded
        wait_idle("rst_idle");
        te_period = 1;
        repeat (2) @(negedge clk);
        base = rx_data.size();
        do_load(8'hFF);
        wait_fall("rst_fall");
        do_load(8'h81);
        chk("rst_held_tbr", 32'(tbr), 32'd0);
        repeat (68) @(negedge clk);
        chk("rst_busy_bit3", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_txd", 32'(txd), 32'd1);
        chk("rst_mid_tbr", 32'(tbr), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        chk("rst_discard", 32'(rx_data.size()), 32'(base));
        do_load(8'h3C);
        exp_q.push_back(8'h3C);
        wait_rx("rst_3c_rx", base + 1);
        check_frames();

        // Loopback decode of 0xC3
        wait_idle("c3_idle");
        do_load(8'hC3);
        exp_q.push_back(8'hC3);
        wait_rx("c3_rx", exp_q.size());
        check_frames();

`ifdef UART_TX_PARITY_EN
        wait_idle("p07_idle");
        do_load(8'h07);
        exp_q.push_back(8'h07);
        wait_rx("p07_rx", exp_q.size());
        check_frames();
        chk("parity_07", 32'(rx_par[rx_par.size()-1]), 32'd1);
        wait_idle("p03_idle");
        do_load(8'h03);
        exp_q.push_back(8'h03);
        wait_rx("p03_rx", exp_q.size());
        check_frames();
        chk("parity_03", 32'(rx_par[rx_par.size()-1]), 32'd0);
`endif

        chk("off_tick_total", 32'(off_tick), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- 8N1 UART transmit stage, the serial-line counterpart of the team's UART receive block.
- Accepts a byte from the bus-side interface through a one-byte holding register and shifts it out LSB-first on txd.
- Uses the same 16x oversampling tick as the receive block, so a looped-back txd decodes there unchanged.
- Double-buffered: the next byte can be written while the current frame is shifting.

Parameters:
- OVERSAMPLE, 16, t_enable ticks per serial bit; must be 2..256.
- DATA_BITS, 8, payload bits per frame; fixed at 8 in this revision.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- t_enable  input  1  oversample tick, one clk cycle wide, OVERSAMPLE per bit period
- load  input  1  write strobe for din, one cycle
- din  input  8  byte to transmit
- txd  output  1  serial line, idles high
- tbr  output  1  transmit buffer ready; holding register empty, load accepted
- busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset values (rst sampled high at posedge): txd=1, tbr=1, busy=0, holding register empty, shift register 0, tick counter 0, bit counter 0, state IDLE. Reset mid-frame abandons the frame; txd is 1 on the next cycle; any held byte is discarded.
- Load rules:
  - load with tbr=1 captures din into the holding register at that edge; tbr=0 from the next cycle.
  - load with tbr=0 is ignored; the held and shifting data are unaffected and no error flag is raised.
- States: IDLE, START, DATA, STOP (plus PARITY under the optional feature).
- IDLE: txd=1. Transfer happens only on a cycle where the holding register is full and t_enable=1. On that edge:
  - shift register <= holding register;
  - holding register is emptied, so tbr=1 on the next cycle;
  - state goes to START and txd=0;
  - tick counter <= OVERSAMPLE-1.
- Bit timing: every t_enable=1 cycle decrements the tick counter. When t_enable=1 and the counter is 0, the bit ends:
  - counter reloads to OVERSAMPLE-1;
  - the state or bit index advances;
  - txd takes the new value at that edge.
  Each bit is therefore exactly OVERSAMPLE ticks long. With t_enable=0, all state is frozen except load acceptance.
- START -> DATA: txd = shift[0]. The 3-bit bit counter starts at 0.
- DATA: at the end of each bit, shift right and increment the counter. After bit 7 (counter == 7), go to STOP with txd=1. The counter wraps to 0.
- STOP: txd=1 for OVERSAMPLE ticks. At the end of the stop bit:
  - if the holding register is full, enter START directly (txd=0, same transfer action as IDLE), giving back-to-back frames with no idle gap;
  - otherwise enter IDLE.
- A load on the same cycle as a transfer cannot occur, because tbr=0 whenever the holding register is full.
- Latency from an accepted load to the txd falling edge is at most one tick period from IDLE, plus the remaining current frame if busy.
- Frame length is 10*OVERSAMPLE ticks.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - a PARITY state follows DATA;
  - txd = even parity (XOR of the 8 data bits, latched at transfer) for OVERSAMPLE ticks, then STOP;
  - frame length is 11*OVERSAMPLE ticks.
- Undefined: DATA goes directly to STOP; no parity logic is synthesised.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constants UART_OVERSAMPLE=16 and UART_DATA_BITS=8, shared with the receive block.
- Sub-module uart_bit_timer: the reloadable down-counter gated by t_enable, outputting bit_end. It is reused by the receive block.

Test Plan:
- Reset, t_enable every cycle, load 0xA5:
  - txd low 16 cycles, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then high 16 cycles;
  - tbr=1 one cycle after the transfer; busy=0 after the stop bit.
- Load 0x55, then load 0x0F as soon as tbr=1: the second start bit immediately follows the first stop bit; both frames total 320 ticks with no idle gap.
- Third load issued while tbr=0 (during the back-to-back sequence): that byte is dropped, and the txd stream carries only 0x55 and 0x0F.
- t_enable asserted every 4th clk: each bit is 64 clk cycles wide, and txd changes only on t_enable cycles.
- rst asserted during data bit 3 of 0xFF:
  - next cycle txd=1, tbr=1, busy=0;
  - a following load of 0x3C transmits a clean frame.
- Loopback txd into the receive block with a shared t_enable, send 0xC3: the receive block reports data=0xC3 with no bit errors.
- With UART_TX_PARITY_EN: send 0x07 and check for an extra bit of 1 before the stop bit; send 0x03 and check that the parity bit is 0.
